// File: rtl/regfile_dumper_if.sv
// Output word stream of the register file dumper.
// master drives tx_data/tx_valid, slave returns tx_ready.
interface regfile_dumper_if;
    logic [18:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/regfile_dumper.sv
// Streams selected registers R[i] out as {i, value}, lowest index first.
// Ports: clk, reset (sync, low), start/abort/mask control, SR_r/Out_r
// debug read port, tx word stream, busy/done/word_cnt status.
module regfile_dumper (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [7:0]               mask,
    output logic [2:0]               SR_r,
    input  logic [15:0]              Out_r,
    regfile_dumper_if.master         tx,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic [7:0]  pend, pend_n;
    logic [2:0]  idx, idx_n;
    logic [3:0]  cnt_n;
    logic [18:0] data_q, data_n;
    logic [7:0]  rem;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            pend     <= '0;
            idx      <= '0;
            word_cnt <= '0;
            data_q   <= '0;
        end else begin
            state    <= state_n;
            pend     <= pend_n;
            idx      <= idx_n;
            word_cnt <= cnt_n;
            data_q   <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        pend_n  = pend;
        idx_n   = idx;
        cnt_n   = word_cnt;
        data_n  = data_q;
        rem     = pend & ~(8'(1) << idx);
        unique case (state)
            S_IDLE: begin
                // abort in IDLE blocks a same-cycle start
                if (start && !abort) begin
                    cnt_n = '0;
                    if (mask != '0) begin
                        pend_n  = mask;
                        idx_n   = lowest(mask);
                        state_n = S_SELECT;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_SELECT: state_n = S_WAIT;
            S_WAIT: begin
                // Out_r now reflects R[idx] selected during SELECT
                data_n  = {idx, Out_r};
                state_n = S_SEND;
            end
            S_SEND: begin
                if (tx.tx_ready) begin
                    pend_n = rem;
                    cnt_n  = 4'(word_cnt + 4'd1);
                    if (rem != '0) begin
                        idx_n   = lowest(rem);
                        state_n = S_SELECT;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // abort wins over a same-edge handshake; accepted words stay counted
        if (abort && state != S_IDLE) begin
            state_n = S_IDLE;
            pend_n  = pend;
            idx_n   = idx;
            cnt_n   = word_cnt;
            data_n  = data_q;
        end
    end

    assign SR_r        = idx;
    assign tx.tx_data  = data_q;
    assign tx.tx_valid = (state == S_SEND);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 The port list SHALL be exactly as follows; the block SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-002 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  in  1  synchronous, active-low; sampled low on a rising edge SHALL reset the block.
REQ-004 start  in  1  dump request; sampled only in IDLE.
REQ-005 abort  in  1  terminates an in-progress dump.
REQ-006 mask  in  8  register select; bit i set dumps R[i]; captured on accepted start.
REQ-007 SR_r  out  3  debug read select to the register file debug port (clocked by clk).
REQ-008 Out_r  in  16  registered debug read data; valid one clk edge after SR_r is stable.
REQ-009 tx_data  out  19  {index[2:0], value[15:0]}.
REQ-010 tx_valid  out  1  tx_data valid.
REQ-011 tx_ready  in  1  consumer accepts the word.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse at dump completion.
REQ-014 word_cnt  out  4  words accepted in the current dump, 0..8.

Function
REQ-015 States SHALL be IDLE, SELECT, WAIT, SEND and DONE.
REQ-016 IDLE: start=1 with mask!=0 SHALL capture mask into pend, load idx = lowest set bit, clear word_cnt and go to SELECT.
REQ-017 IDLE: start=1 with mask==0 SHALL clear word_cnt and go directly to DONE.
REQ-018 SR_r SHALL be registered and SHALL equal idx throughout SELECT, WAIT and SEND.
REQ-019 SELECT SHALL last one cycle, then go to WAIT (Out_r updates at the end of SELECT).
REQ-020 WAIT SHALL last one cycle; at its closing edge tx_data SHALL be loaded with {idx, Out_r}; next state is SEND.
REQ-021 SEND: tx_valid SHALL be 1, and tx_data SHALL be held stable until handshake.
REQ-022 Handshake SHALL be tx_valid & tx_ready at a rising edge; on handshake the block SHALL clear pend[idx] and increment word_cnt.
REQ-023 On handshake, if any pend bit remains set, idx SHALL take the lowest remaining set bit and the state SHALL go to SELECT; otherwise the state SHALL go to DONE.
REQ-024 Word order SHALL be ascending index; no index SHALL be emitted twice or skipped.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; word_cnt SHALL hold its value until the next accepted start.
REQ-026 Latency: start sampled at edge N SHALL give tx_valid=1 from cycle N+3; with tx_ready held at 1, the block SHALL emit one word per 3 cycles.
REQ-027 A full mask (8'hFF) with tx_ready=1 SHALL assert done 24 cycles after the start edge.
REQ-028 start while busy SHALL be ignored; changes on mask while busy SHALL be ignored.
REQ-029 abort=1 in any non-IDLE state SHALL go to IDLE next edge with tx_valid=0 and done=0; abort SHALL take priority over a same-edge handshake; word_cnt SHALL retain words already accepted.
REQ-030 abort in IDLE SHALL have no effect; abort and start together in IDLE SHALL not start a dump.
REQ-031 tx_valid SHALL never deassert without a handshake, except on abort or reset.

Reset
REQ-032 reset=0 at an edge SHALL force the state to IDLE and clear SR_r, tx_data, tx_valid, busy, done, word_cnt, pend and idx to 0.
REQ-033 Reset SHALL override start, abort and handshake; a reset mid-dump SHALL discard the dump with no done pulse.

Verification
REQ-034 R0..R7 preset to 16'h1000+i; mask=8'hFF; tx_ready=1; pulse start -> 8 words 16'h1000..16'h1007 with indices 0..7; done 24 cycles after start; word_cnt=8.
REQ-035 mask=8'b1010_0100 -> words for indices 2, 5, 7 only, in that order; word_cnt=3.
REQ-036 mask=8'hFF; tx_ready low for 5 cycles in SEND of index 3 -> tx_data held at {3, 16'h1003}; no duplicate and no skip; done still fires once.
REQ-037 mask=0; pulse start -> done pulses on the second edge; no tx_valid; word_cnt=0.
REQ-038 abort asserted during WAIT of index 4 (R0..R3 already accepted) -> IDLE next edge; no done; word_cnt=4; a new start re-dumps from index 0.
REQ-039 reset=0 asserted during SEND -> all outputs 0 the next cycle; start pulse and handshake on the same edge ignored.
